// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream packet generator and its keep logic.
package axis_gen_pkg;

    localparam int DEF_TDATA_WIDTH = 512;
    localparam int DEF_TKEEP_WIDTH = DEF_TDATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Ceiling log2; sizes the byte-count bus so it can hold TKEEP_WIDTH itself.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_flit_gen_keep_from_count.sv
// Byte count -> contiguous tkeep mask. Counts at or above KEEP_WIDTH saturate to all ones.
module keep_from_count
    import axis_gen_pkg::*;
#(
    parameter  int KEEP_WIDTH = DEF_TKEEP_WIDTH,
    localparam int CW         = log2(KEEP_WIDTH) + 1
) (
    input  logic [CW-1:0]         count,
    output logic [KEEP_WIDTH-1:0] keep
);

    // Enable every byte lane whose index is below the count.
    always_comb begin
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            keep[k] = (k < int'(count));
        end
    end

endmodule

// File: rtl/axis_flit_gen.sv
// AXI4-Stream packet generator: turns a byte-length command into full-width flits
// with an incrementing byte pattern, a remaining-count tkeep and tlast on the final flit.
module axis_flit_gen
    import axis_gen_pkg::*;
#(
    parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic [31:0]            pkt_count
);

    localparam int                   CW         = log2(TKEEP_WIDTH) + 1;
    localparam logic [LEN_WIDTH-1:0] FLIT_BYTES = LEN_WIDTH'(TKEEP_WIDTH);

    state_t                 state, state_next;
    logic [LEN_WIDTH-1:0]   remaining, rem_next;
    logic [LEN_WIDTH-1:0]   flit_idx, idx_next;
    logic                   load_flit;
    logic                   end_pkt;
    logic                   xfer;

    logic                   flit_full;
    logic                   flit_last;
    logic [CW-1:0]          keep_count;
    logic [TKEEP_WIDTH-1:0] flit_keep;
    logic [TDATA_WIDTH-1:0] flit_data;
    logic [7:0]             base_byte;

    assign xfer      = m_axis_tvalid && m_axis_tready;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SEND);

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: command acceptance, flit advance and end of packet.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned and no latch is inferred.
        state_next = state;
        rem_next   = remaining;
        idx_next   = flit_idx;
        load_flit  = 1'b0;
        end_pkt    = 1'b0;
        unique case (state)
            IDLE: begin
                // A zero-length command is consumed here and simply dropped.
                if (cmd_valid && cmd_len != '0) begin
                    state_next = SEND;
                    rem_next   = cmd_len;
                    idx_next   = '0;
                    load_flit  = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (m_axis_tlast) begin
                        state_next = IDLE;
                        end_pkt    = 1'b1;
                    end else begin
                        // Last-flit test above guarantees remaining > FLIT_BYTES here.
                        rem_next  = remaining - FLIT_BYTES;
                        idx_next  = flit_idx + 1'b1;
                        load_flit = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clamp the remaining count into the keep generator's range.
    always_comb begin
        flit_full  = (rem_next >= FLIT_BYTES);
        flit_last  = (rem_next <= FLIT_BYTES);
        keep_count = flit_full ? CW'(TKEEP_WIDTH) : rem_next[CW-1:0];
    end

    keep_from_count #(
        .KEEP_WIDTH (TKEEP_WIDTH)
    ) u_keep (
        .count (keep_count),
        .keep  (flit_keep)
    );

    // Byte k of flit n carries (n*TKEEP_WIDTH + k) mod 256; disabled lanes are zero.
    always_comb begin
        base_byte = 8'(idx_next * FLIT_BYTES);
        flit_data = '0;
        for (int k = 0; k < TKEEP_WIDTH; k++) begin
            flit_data[8*k +: 8] = flit_keep[k] ? (base_byte + 8'(k)) : 8'h00;
        end
    end

    // Registered flit presentation, packet bookkeeping and packet counter.
    always_ff @(posedge clk) begin
        // NOTE: the wide datapath is reset too, so tdata/tkeep read as zero while idle.
        if (!aresetn) begin
            remaining     <= '0;
            flit_idx      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tdata  <= '0;
            pkt_count     <= '0;
        end else begin
            remaining <= rem_next;
            flit_idx  <= idx_next;
            if (load_flit) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= flit_last;
                m_axis_tkeep  <= flit_keep;
                m_axis_tdata  <= flit_data;
            end else if (end_pkt) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tkeep  <= '0;
                m_axis_tdata  <= '0;
            end
            if (end_pkt) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_flit_gen.sv
// Self-checking bench for axis_flit_gen: table-driven packets, hand-written corner
// sequences and randomized packets against a byte-level reference model.
module tb_axis_flit_gen;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          busy;
    logic [31:0]   pkt_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_pkts = 0;

    typedef struct {
        int          len;
        int          mode;      // 0: always ready, 1: random ready, 2: 1-0-0-1 pattern
        int          flits;
        logic [63:0] last_keep;
    } vec_t;

    axis_flit_gen #(
        .TDATA_WIDTH (DW),
        .TKEEP_WIDTH (KW),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: global byte g = n*KW + k exists iff g < len and carries g mod 256.
    function automatic logic [DW-1:0] model_data(input int len, input int n);
        logic [DW-1:0] d;
        int g;
        d = '0;
        for (int k = 0; k < KW; k++) begin
            g = n * KW + k;
            if (g < len) d[8*k +: 8] = 8'(g);
        end
        return d;
    endfunction

    function automatic logic [KW-1:0] model_keep(input int len, input int n);
        logic [KW-1:0] m;
        m = '0;
        for (int k = 0; k < KW; k++) begin
            m[k] = ((n * KW + k) < len);
        end
        return m;
    endfunction

    function automatic logic model_last(input int len, input int n);
        return ((n + 1) * KW >= len);
    endfunction

    task automatic run_pkt(input int len, input int mode, input int exp_flits,
                           input logic [63:0] exp_last_keep, input bit use_exp);
        int            n, bytes, cyc, pat;
        bit            got_last, stalled;
        logic [DW-1:0] hold_data;
        logic [KW+1:0] hold_ctl;
        logic [KW-1:0] last_keep;
        n = 0; bytes = 0; cyc = 0; pat = 0;
        got_last = 1'b0; stalled = 1'b0;
        hold_data = '0; hold_ctl = '0; last_keep = '0;

        while (!cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("tvalid_latency", m_axis_tvalid, 1);
        check("busy_in_send", busy, 1);
        check("cmd_ready_low", cmd_ready, 0);

        cyc = 0;
        while (!got_last && cyc < 4000) begin
            if (stalled) begin
                check("stall_hold_data", m_axis_tdata, hold_data);
                check("stall_hold_ctl", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep}, hold_ctl);
            end
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = (pat % 4 == 0) || (pat % 4 == 3);
            endcase
            pat++;
            if (m_axis_tvalid && m_axis_tready) begin
                check("flit_data", m_axis_tdata, model_data(len, n));
                check("flit_keep", m_axis_tkeep, model_keep(len, n));
                check("flit_last", m_axis_tlast, model_last(len, n));
                bytes     += $countones(m_axis_tkeep);
                last_keep  = m_axis_tkeep;
                got_last   = m_axis_tlast;
                n++;
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            hold_data = m_axis_tdata;
            hold_ctl  = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep};
            @(negedge clk);
            cyc++;
        end
        if (!got_last) check("packet_timeout", 0, 1);
        m_axis_tready = 1'b1;
        exp_pkts++;

        check("tvalid_after_last", m_axis_tvalid, 0);
        check("cmd_ready_after_bubble", cmd_ready, 1);
        check("busy_after_last", busy, 0);
        check("pkt_count", pkt_count, 32'(exp_pkts));
        check("total_bytes", bytes, len);
        check("flit_count_model", n, (len + KW - 1) / KW);
        if (use_exp) begin
            check("flit_count_table", n, exp_flits);
            check("last_keep_table", last_keep, exp_last_keep);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        logic [DW-1:0] d;

        vecs[0] = '{len: 64,    mode: 0, flits: 1,    last_keep: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{len: 1,     mode: 0, flits: 1,    last_keep: 64'h1};
        vecs[2] = '{len: 130,   mode: 0, flits: 3,    last_keep: 64'h3};
        vecs[3] = '{len: 200,   mode: 2, flits: 4,    last_keep: 64'hFF};
        vecs[4] = '{len: 10,    mode: 1, flits: 1,    last_keep: 64'h3FF};
        vecs[5] = '{len: 128,   mode: 1, flits: 2,    last_keep: 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{len: 63,    mode: 0, flits: 1,    last_keep: 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[7] = '{len: 65535, mode: 0, flits: 1024, last_keep: 64'h7FFF_FFFF_FFFF_FFFF};

        aresetn       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_len       = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_pkt_count", pkt_count, 0);
        aresetn = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Explicit spot checks of the 130-byte case on top of the model.
        for (int i = 0; i < 8; i++) begin
            run_pkt(vecs[i].len, vecs[i].mode, vecs[i].flits, vecs[i].last_keep, 1'b1);
        end
        d = model_data(130, 2);
        check("model_130_f2_b0", d[7:0], 8'h80);
        check("model_130_f2_b1", d[15:8], 8'h81);

        // Zero-length command is consumed without output, then a 65-byte packet.
        cmd_len   = '0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("zero_cmd_ready", cmd_ready, 1);
        check("zero_tvalid", m_axis_tvalid, 0);
        check("zero_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("zero_tvalid_later", m_axis_tvalid, 0);
        check("zero_pkt_count", pkt_count, 32'(exp_pkts));
        run_pkt(65, 0, 2, 64'h1, 1'b1);

        // Command held through the last transfer must wait out the bubble.
        cmd_len   = LW'(64);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_valid", m_axis_tvalid, 1);
        @(negedge clk);
        exp_pkts++;
        check("b2b_bubble_tvalid", m_axis_tvalid, 0);
        check("b2b_bubble_ready", cmd_ready, 1);
        check("b2b_count1", pkt_count, 32'(exp_pkts));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_second_valid", m_axis_tvalid, 1);
        check("b2b_second_keep", m_axis_tkeep, {KW{1'b1}});
        check("b2b_second_last", m_axis_tlast, 1);
        @(negedge clk);
        exp_pkts++;
        check("b2b_end_tvalid", m_axis_tvalid, 0);
        check("b2b_count2", pkt_count, 32'(exp_pkts));

        // Reset while flit 1 of a 300-byte packet is on the bus.
        cmd_len   = LW'(300);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_flit1_valid", m_axis_tvalid, 1);
        check("rst_mid_flit1_data", m_axis_tdata, model_data(300, 1));
        check("rst_mid_flit1_last", m_axis_tlast, 0);
        aresetn       = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("rst_mid_tvalid", m_axis_tvalid, 0);
        check("rst_mid_tlast", m_axis_tlast, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pkt_count", pkt_count, 0);
        exp_pkts      = 0;
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        run_pkt(10, 0, 1, 64'h3FF, 1'b1);

        // Randomized packets against the model.
        for (int i = 0; i < 25; i++) begin
            run_pkt($urandom_range(1, 300), 1, 0, '0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
